// File: rtl/ssha3_agen.sv
// ssha3_agen: sequential Keccak-f lane address generator for the scalar SHA3
// datapath. One start handshake produces 25 lane byte addresses, one per
// valid/ready beat, walking source (x,y) with x as the inner counter.
//
// Optional feature macro: SSHA3_AGEN_RHO_EN (adds the rot_amt output).
//
// Ports:
//   g_clk, g_resetn          clock, asynchronous active-low reset
//   start_valid/start_ready  start handshake (ready only while idle)
//   mode                     0=XY 1=X1 2=X2 3=X4 4=YX, 5..7 illegal
//   base                     state base byte address, sampled on start
//   abort                    cancel current sequence (RUN only)
//   addr_valid/addr_ready    address beat handshake
//   addr                     base + (index << LANE_SHIFT), wraps mod 2^XLEN
//   addr_x, addr_y           source lane coordinates of the current beat
//   addr_last                high on the final beat (x=4, y=4)
//   err                      one-cycle pulse after a start with illegal mode
//   rot_amt                  (SSHA3_AGEN_RHO_EN) rho offset of the source lane
module ssha3_agen #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned LANE_SHIFT = 2
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [2:0]            mode,
  input  logic [XLEN-1:0]       base,
  input  logic                  abort,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic [XLEN-1:0]       addr,
  output logic [2:0]            addr_x,
  output logic [2:0]            addr_y,
  output logic                  addr_last,
  output logic                  err
`ifdef SSHA3_AGEN_RHO_EN
  ,
  output logic [LANE_SHIFT+2:0] rot_amt
`endif
);

  localparam int unsigned IDX_W = 5;

  localparam logic [2:0] MODE_XY = 3'd0;
  localparam logic [2:0] MODE_X1 = 3'd1;
  localparam logic [2:0] MODE_X2 = 3'd2;
  localparam logic [2:0] MODE_X4 = 3'd3;
  localparam logic [2:0] MODE_YX = 3'd4;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      x_q, x_d;
  logic [2:0]      y_q, y_d;
  logic [2:0]      mode_q, mode_d;
  logic [XLEN-1:0] base_q, base_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            last_q, last_d;
  logic            err_q, err_d;
  logic [2:0]      col, row;
  logic [IDX_W-1:0] idx;

  // Reduce a value in 0..9 modulo 5 with a single compare-subtract.
  function automatic logic [2:0] mod5_small(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : 3'(v);
  endfunction

  // Reduce a value in 0..14 modulo 5 with a two-step compare-subtract.
  function automatic logic [2:0] mod5_wide(input logic [3:0] v);
    if (v >= 4'd10)     return 3'(v - 4'd10);
    else if (v >= 4'd5) return 3'(v - 4'd5);
    else                return 3'(v);
  endfunction

`ifdef SSHA3_AGEN_RHO_EN
  logic [LANE_SHIFT+2:0] rot_q, rot_d;
  logic [5:0]            rho_full;

  // Keccak rho offsets indexed by source (x,y).
  function automatic logic [5:0] rho_lut(input logic [2:0] x, input logic [2:0] y);
    case ({y, x})
      {3'd0, 3'd0}: return 6'd0;
      {3'd0, 3'd1}: return 6'd1;
      {3'd0, 3'd2}: return 6'd62;
      {3'd0, 3'd3}: return 6'd28;
      {3'd0, 3'd4}: return 6'd27;
      {3'd1, 3'd0}: return 6'd36;
      {3'd1, 3'd1}: return 6'd44;
      {3'd1, 3'd2}: return 6'd6;
      {3'd1, 3'd3}: return 6'd55;
      {3'd1, 3'd4}: return 6'd20;
      {3'd2, 3'd0}: return 6'd3;
      {3'd2, 3'd1}: return 6'd10;
      {3'd2, 3'd2}: return 6'd43;
      {3'd2, 3'd3}: return 6'd25;
      {3'd2, 3'd4}: return 6'd39;
      {3'd3, 3'd0}: return 6'd41;
      {3'd3, 3'd1}: return 6'd45;
      {3'd3, 3'd2}: return 6'd15;
      {3'd3, 3'd3}: return 6'd21;
      {3'd3, 3'd4}: return 6'd8;
      {3'd4, 3'd0}: return 6'd18;
      {3'd4, 3'd1}: return 6'd2;
      {3'd4, 3'd2}: return 6'd61;
      {3'd4, 3'd3}: return 6'd56;
      {3'd4, 3'd4}: return 6'd14;
      default:      return 6'd0;
    endcase
  endfunction

  assign rot_amt = rot_q;
`endif

  // State and datapath registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SSHA3_AGEN_RHO_EN
      rot_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      err_q   <= err_d;
`ifdef SSHA3_AGEN_RHO_EN
      rot_q   <= rot_d;
`endif
    end
  end

  // Next-state logic: start acceptance, beat stepping, abort.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    base_d  = base_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          if (mode <= MODE_YX) begin
            state_d = S_RUN;
            mode_d  = mode;
            base_d  = base;
            x_d     = '0;
            y_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        // abort wins over a same-cycle handshake; the offered beat is dropped
        if (abort) begin
          state_d = S_IDLE;
          x_d     = '0;
          y_d     = '0;
        end else if (addr_ready) begin
          if (x_q == 3'd4 && y_q == 3'd4) begin
            state_d = S_IDLE;
            x_d     = '0;
            y_d     = '0;
          end else if (x_q < 3'd4) begin
            x_d = 3'(x_q + 3'd1);
          end else begin
            x_d = '0;
            y_d = 3'(y_q + 3'd1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: lane index mapping for the next beat plus status decode.
  always_comb begin
    col = x_d;
    row = y_d;
    case (mode_d)
      MODE_XY: begin col = x_d; row = y_d; end
      MODE_X1: begin col = mod5_small({1'b0, x_d} + 4'd1); row = y_d; end
      MODE_X2: begin col = mod5_small({1'b0, x_d} + 4'd2); row = y_d; end
      MODE_X4: begin col = mod5_small({1'b0, x_d} + 4'd4); row = y_d; end
      MODE_YX: begin
        // (2x + 3y) mod 5, reducing each term before the final sum
        col = y_d;
        row = mod5_small({1'b0, mod5_small({x_d, 1'b0})} +
                         {1'b0, mod5_wide({1'b0, y_d} + {y_d, 1'b0})});
      end
      default: begin col = x_d; row = y_d; end
    endcase
    idx    = 5'({row, 2'b00}) + 5'(row) + 5'(col);
    addr_d = base_d + (XLEN'(idx) << LANE_SHIFT);
    last_d = (state_d == S_RUN) && (x_d == 3'd4) && (y_d == 3'd4);
`ifdef SSHA3_AGEN_RHO_EN
    rho_full = rho_lut(x_d, y_d);
    rot_d    = rho_full[LANE_SHIFT+2:0];
`endif
    start_ready = (state_q == S_IDLE);
    addr_valid  = (state_q == S_RUN);
  end

  assign addr      = addr_q;
  assign addr_x    = x_q;
  assign addr_y    = y_q;
  assign addr_last = last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ssha3_agen.sv
module tb_ssha3_agen;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  x;
    logic [2:0]  y;
    logic        last;
    logic [5:0]  rot;
  } exp_t;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        start_valid;
  logic [2:0]  mode;
  logic [31:0] base;
  logic        abort;
  logic        addr_ready;

  logic        start_ready2, addr_valid2, addr_last2, err2;
  logic [31:0] addr2;
  logic [2:0]  addr_x2, addr_y2;
  logic        start_ready3, addr_valid3, addr_last3, err3;
  logic [31:0] addr3;
  logic [2:0]  addr_x3, addr_y3;
  logic [5:0]  rot2_w, rot3_w;
`ifdef SSHA3_AGEN_RHO_EN
  logic [4:0]  rot_amt2;
  logic [5:0]  rot_amt3;
  assign rot2_w = {1'b0, rot_amt2};
  assign rot3_w = rot_amt3;
`else
  assign rot2_w = 6'd0;
  assign rot3_w = 6'd0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t q [2][$];
  logic        stall  [2];
  logic [31:0] s_addr [2];
  logic [2:0]  s_x    [2];
  logic [2:0]  s_y    [2];

  int rho_t [5][5] = '{'{0, 1, 62, 28, 27},
                       '{36, 44, 6, 55, 20},
                       '{3, 10, 43, 25, 39},
                       '{41, 45, 15, 21, 8},
                       '{18, 2, 61, 56, 14}};

  always #5 g_clk = ~g_clk;

  ssha3_agen #(.XLEN(32), .LANE_SHIFT(2)) dut2 (
    .g_clk(g_clk), .g_resetn(g_resetn), .start_valid(start_valid),
    .start_ready(start_ready2), .mode(mode), .base(base), .abort(abort),
    .addr_valid(addr_valid2), .addr_ready(addr_ready), .addr(addr2),
    .addr_x(addr_x2), .addr_y(addr_y2), .addr_last(addr_last2), .err(err2)
`ifdef SSHA3_AGEN_RHO_EN
    , .rot_amt(rot_amt2)
`endif
  );

  ssha3_agen #(.XLEN(32), .LANE_SHIFT(3)) dut3 (
    .g_clk(g_clk), .g_resetn(g_resetn), .start_valid(start_valid),
    .start_ready(start_ready3), .mode(mode), .base(base), .abort(abort),
    .addr_valid(addr_valid3), .addr_ready(addr_ready), .addr(addr3),
    .addr_x(addr_x3), .addr_y(addr_y3), .addr_last(addr_last3), .err(err3)
`ifdef SSHA3_AGEN_RHO_EN
    , .rot_amt(rot_amt3)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lane index from the mode's arithmetic definition.
  task automatic push_seq(input logic [2:0] m, input logic [31:0] b);
    for (int n = 0; n < 25; n++) begin
      int x, y, idx;
      x = n % 5;
      y = n / 5;
      case (m)
        3'd0: idx = x + 5 * y;
        3'd1: idx = (x + 1) % 5 + 5 * y;
        3'd2: idx = (x + 2) % 5 + 5 * y;
        3'd3: idx = (x + 4) % 5 + 5 * y;
        default: idx = y + 5 * ((2 * x + 3 * y) % 5);
      endcase
      for (int k = 0; k < 2; k++) begin
        exp_t e;
        longint unsigned full;
        full   = longint'(b) + longint'(idx) * (longint'(1) << (k + 2));
        e.addr = full[31:0];
        e.x    = 3'(x);
        e.y    = 3'(y);
        e.last = (n == 24);
        e.rot  = 6'(rho_t[y][x] % (1 << (k + 5)));
        q[k].push_back(e);
      end
    end
  endtask

  task automatic monitor(input int k, input logic v, input logic [31:0] a,
                         input logic [2:0] ax, input logic [2:0] ay,
                         input logic l, input logic [5:0] r);
    if (v && stall[k]) begin
      check($sformatf("stable_addr%0d", k), 64'(a), 64'(s_addr[k]));
      check($sformatf("stable_xy%0d", k), 64'({ax, ay}), 64'({s_x[k], s_y[k]}));
    end
    if (v && addr_ready && !abort) begin
      if (q[k].size() == 0) begin
        check($sformatf("unexpected_beat%0d", k), 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = q[k].pop_front();
        check($sformatf("addr%0d", k), 64'(a), 64'(e.addr));
        check($sformatf("addr_xy%0d", k), 64'({ax, ay}), 64'({e.x, e.y}));
        check($sformatf("addr_last%0d", k), 64'(l), 64'(e.last));
`ifdef SSHA3_AGEN_RHO_EN
        check($sformatf("rot_amt%0d", k), 64'(r), 64'(e.rot));
`else
        if (r != 6'd0) check($sformatf("rot_tie%0d", k), 64'(r), 64'(0));
`endif
      end
      stall[k] = 1'b0;
    end else if (v && !addr_ready && !abort) begin
      stall[k]  = 1'b1;
      s_addr[k] = a;
      s_x[k]    = ax;
      s_y[k]    = ay;
    end else begin
      stall[k] = 1'b0;
    end
  endtask

  always @(negedge g_clk) begin
    if (g_resetn) begin
      monitor(0, addr_valid2, addr2, addr_x2, addr_y2, addr_last2, rot2_w);
      monitor(1, addr_valid3, addr3, addr_x3, addr_y3, addr_last3, rot3_w);
    end else begin
      stall[0] = 1'b0;
      stall[1] = 1'b0;
    end
  end

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  // Issue a start; returns #1 after the handshake edge (first beat cycle).
  task automatic do_start(input logic [2:0] m, input logic [31:0] b);
    int n = 0;
    while (!start_ready2 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("start_ready_timeout", 64'(0), 64'(1));
    start_valid = 1'b1;
    mode        = m;
    base        = b;
    @(posedge g_clk);
    if (m <= 3'd4) push_seq(m, b);
    #1;
    start_valid = 1'b0;
    mode        = 3'd0;
  endtask

  task automatic drain(input bit bp);
    int n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 2000) begin
      if (bp) addr_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    addr_ready = 1'b1;
    if (n >= 2000) check("drain_timeout", 64'(n), 64'(0));
    check("idle_valid2", 64'(addr_valid2), 64'(0));
    check("idle_valid3", 64'(addr_valid3), 64'(0));
    check("idle_start_ready", 64'(start_ready2), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    stall[0] = 1'b0;
    stall[1] = 1'b0;
    g_resetn    = 1'b0;
    start_valid = 1'b0;
    mode        = 3'd0;
    base        = 32'd0;
    abort       = 1'b0;
    addr_ready  = 1'b1;
    repeat (3) step();
    check("rst_start_ready", 64'(start_ready2), 64'(1));
    check("rst_addr_valid", 64'(addr_valid2), 64'(0));
    check("rst_addr", 64'(addr2), 64'(0));
    check("rst_last_err", 64'({addr_last2, err2, addr_x2, addr_y2}), 64'(0));
    g_resetn = 1'b1;
    step();

    // XY from 0x1000 with full throughput: latency and T+26 idle
    do_start(3'd0, 32'h1000);
    check("first_beat_valid", 64'(addr_valid2), 64'(1));
    check("first_beat_start_ready", 64'(start_ready2), 64'(0));
    repeat (24) step();
    check("t25_start_ready", 64'(start_ready2), 64'(0));
    check("t25_last", 64'(addr_last2), 64'(1));
    step();
    check("t26_start_ready", 64'(start_ready2), 64'(1));
    check("t26_valid", 64'(addr_valid2), 64'(0));
    check("t26_all_beats", 64'(q[0].size()), 64'(0));

    // pi permutation and column offsets
    do_start(3'd4, 32'd0);
    drain(1'b0);
    do_start(3'd3, 32'h80);
    drain(1'b0);
    do_start(3'd1, 32'h200);
    drain(1'b0);
    do_start(3'd2, 32'hFFFF_FFF0);
    drain(1'b0);

    // backpressure on XY
    do_start(3'd0, $urandom);
    drain(1'b1);

    // abort on beat 7 with addr_ready high, then restart from base 0
    addr_ready = 1'b1;
    do_start(3'd0, 32'h4000);
    repeat (7) step();
    check("abort_beat7_xy", 64'({addr_x2, addr_y2}), 64'({3'd2, 3'd1}));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", 64'(addr_valid2), 64'(0));
    check("abort_last", 64'(addr_last2), 64'(0));
    check("abort_start_ready", 64'(start_ready2), 64'(1));
    check("abort_remaining", 64'(q[0].size()), 64'(18));
    q[0].delete();
    q[1].delete();
    do_start(3'd0, 32'd0);
    check("restart_beat0", 64'({addr2, addr_x2, addr_y2}), 64'(0));
    drain(1'b0);

    // illegal mode: err pulse, no beats
    do_start(3'd6, 32'h1234);
    check("err_pulse", 64'({err2, err3}), 64'(2'b11));
    check("err_no_beat", 64'(addr_valid2), 64'(0));
    step();
    check("err_one_cycle", 64'(err2), 64'(0));
    check("err_idle", 64'(start_ready2), 64'(1));

    // abort coinciding with start in IDLE is ignored
    abort = 1'b1;
    do_start(3'd1, 32'h800);
    abort = 1'b0;
    check("start_beats_abort", 64'(addr_valid2), 64'(1));
    drain(1'b1);

    // asynchronous reset mid-sequence
    do_start(3'd4, 32'h100);
    repeat (3) step();
    g_resetn = 1'b0;
    #1;
    check("async_rst_valid", 64'(addr_valid2), 64'(0));
    check("async_rst_ready", 64'(start_ready2), 64'(1));
    q[0].delete();
    q[1].delete();
    step();
    g_resetn = 1'b1;
    step();
    check("post_rst_idle", 64'(addr_valid2), 64'(0));

    // randomized sequences
    for (int i = 0; i < 10; i++) begin
      logic [2:0] m;
      m = 3'($urandom_range(0, 4));
      do_start(m, (i % 3 == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom);
      drain(1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
